bram_word_master: RTL and testbench

BRAM_WORD_MASTER -- requirements
Module: bram_word_master

---
 rtl/bram_word_master.sv | 182 ++++++++++++++++++
 tb/tb_bram_word_master.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_word_master.sv
// bram_word_master: serialises byte/half/word core loads and stores onto a byte-wide BRAM port.
// Optional misalignment trap enabled by defining BRAM_MASTER_ALIGN_CHECK_EN.
module bram_word_master #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_read,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DRAIN,
        RESP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [1:0]            r_cnt;
    logic [1:0]            r_last;
    logic                  r_we;
    logic                  r_signed;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic [31:0]           r_rsp_rdata;
    logic [1:0]            w_req_last;
    logic [1:0]            w_cap_idx;
    logic [31:0]           w_full;
    logic                  w_misalign;

    function automatic logic [31:0] f_extend(
        input logic [31:0] d,
        input logic [1:0]  last,
        input logic        sgn
    );
        logic [31:0] v;
        unique case (last)
            2'd0:    v = {{24{sgn & d[7]}}, d[7:0]};
            2'd1:    v = {{16{sgn & d[15]}}, d[15:0]};
            default: v = d;
        endcase
        return v;
    endfunction

    always_comb begin
        unique case (req_size)
            2'b00:   w_req_last = 2'd0;
            2'b01:   w_req_last = 2'd1;
            default: w_req_last = 2'd3;
        endcase
    end

`ifdef BRAM_MASTER_ALIGN_CHECK_EN
    logic r_err;

    assign w_misalign = ((req_size == 2'b01) && req_addr[0])
                     || (req_size[1] && (req_addr[1:0] != 2'b00));
    assign rsp_err    = r_err;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if (r_state == IDLE && req_valid) begin
            r_err <= w_misalign;
        end
    end
`else
    assign w_misalign = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    // Byte k-1 arrives on mem_rdata while ACCESS is issuing byte k.
    assign w_cap_idx = r_cnt - 2'd1;
    assign rsp_rdata = r_rsp_rdata;

    always_comb begin
        w_full = r_rdata;
        w_full[{r_last, 3'b000} +: 8] = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_read  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = w_misalign ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_read  = !r_we;
                mem_we    = r_we;
                mem_addr  = r_base + ADDR_WIDTH'(r_cnt);
                mem_wdata = r_wdata[{r_cnt, 3'b000} +: 8];
                if (r_cnt == r_last) begin
                    w_next = r_we ? RESP : DRAIN;
                end
            end
            DRAIN: begin
                w_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_base      <= '0;
            r_cnt       <= 2'd0;
            r_last      <= 2'd0;
            r_we        <= 1'b0;
            r_signed    <= 1'b0;
            r_wdata     <= 32'h0;
            r_rdata     <= 32'h0;
            r_rsp_rdata <= 32'h0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_base      <= req_addr;
                        r_cnt       <= 2'd0;
                        r_last      <= w_req_last;
                        r_we        <= req_we;
                        r_signed    <= req_signed;
                        r_wdata     <= req_wdata;
                        r_rdata     <= 32'h0;
                        r_rsp_rdata <= 32'h0;
                    end
                end
                ACCESS: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (!r_we && (r_cnt != 2'd0)) begin
                        r_rdata[{w_cap_idx, 3'b000} +: 8] <= mem_rdata;
                    end
                end
                DRAIN: begin
                    r_rsp_rdata <= f_extend(w_full, r_last, r_signed);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_word_master.sv
// Bench for bram_word_master: directed scenarios plus random traffic against a byte-array model.
// Expectations adapt to BRAM_MASTER_ALIGN_CHECK_EN when it is defined.
module tb_bram_word_master;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [11:0] req_addr = 12'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0] bram    [4096];
    logic [7:0] ref_mem [4096];

    logic        q_rd   [$];
    logic        q_we   [$];
    logic [11:0] q_addr [$];
    logic [7:0]  q_wd   [$];

    always #5 clk = ~clk;

    bram_word_master #(.ADDR_WIDTH(12)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_read   (mem_read),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Registered byte-wide BRAM
    always @(posedge clk) begin
        if (mem_we) bram[mem_addr] <= mem_wdata;
        if (mem_read) mem_rdata <= bram[mem_addr];
    end

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit ref_misalign(input logic [1:0] sz, input logic [11:0] a);
`ifdef BRAM_MASTER_ALIGN_CHECK_EN
        int n = nbytes(sz);
        return (n > 1) && ((int'(a) % n) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [11:0] a, input logic [1:0] sz,
                                             input logic sgn);
        longint v = 0;
        int n = nbytes(sz);
        for (int i = 0; i < n; i++)
            v = v + (longint'(ref_mem[(int'(a) + i) % 4096]) << (8 * i));
        if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [11:0] a, input logic [1:0] sz, input logic [31:0] d);
        for (int i = 0; i < nbytes(sz); i++)
            ref_mem[(int'(a) + i) % 4096] = d[8*i +: 8];
    endtask

    task automatic do_txn(input logic we, input logic [1:0] sz, input logic sgn,
                          input logic [11:0] a, input logic [31:0] wd, input int hold,
                          output int lat, output logic [31:0] rd, output logic err,
                          output logic rdy_ok, output logic stable);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = a;
        req_wdata  = wd;
        rsp_ready  = 1'b0;
        rdy_ok     = req_ready;
        @(posedge clk);
        #1 req_valid = 1'b0;
        q_rd.delete(); q_we.delete(); q_addr.delete(); q_wd.delete();
        lat = -1; rd = 32'h0; err = 1'b0; stable = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = c;
                break;
            end
            q_rd.push_back(mem_read);
            q_we.push_back(mem_we);
            q_addr.push_back(mem_addr);
            q_wd.push_back(mem_wdata);
        end
        if (lat > 0) begin
            rd  = rsp_rdata;
            err = rsp_err;
            repeat (hold) begin
                @(negedge clk);
                if (!rsp_valid || rsp_rdata !== rd || rsp_err !== err
                    || req_ready || mem_read || mem_we)
                    stable = 1'b0;
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_err, mem_read, mem_we} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl got %b expected 10000",
                     {req_ready, rsp_valid, rsp_err, mem_read, mem_we});
        end
        checks++;
        if (rsp_rdata !== 32'h0 || mem_addr !== 12'h0 || mem_wdata !== 8'h0) begin
            errors++;
            $display("FAIL reset_data got rdata=%h addr=%h wdata=%h expected zeros",
                     rsp_rdata, mem_addr, mem_wdata);
        end
        resetn = 1'b1;
    endtask

    task automatic test_store_load;
        int lat; logic [31:0] rd; logic err, rdy, st;
        logic [7:0] exp_b [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_txn(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 0, lat, rd, err, rdy, st);
        ref_store(12'h010, 2'b10, 32'hDEADBEEF);
        checks++;
        if (!rdy || lat != 5 || rd !== 32'h0 || err !== 1'b0) begin
            errors++;
            $display("FAIL word_store rdy=%b lat=%0d rdata=%h err=%b expected 1/5/0/0",
                     rdy, lat, rd, err);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k >= q_we.size() || q_we[k] !== 1'b1 || q_rd[k] !== 1'b0
                || q_addr[k] !== 12'h010 + 12'(k) || q_wd[k] !== exp_b[k]) begin
                errors++;
                $display("FAIL word_store_byte%0d got we=%b addr=%h data=%h expected 1/%h/%h",
                         k, (k < q_we.size()) ? q_we[k] : 1'bx,
                         (k < q_addr.size()) ? q_addr[k] : 12'hx,
                         (k < q_wd.size()) ? q_wd[k] : 8'hx, 12'h010 + 12'(k), exp_b[k]);
            end
        end
        do_txn(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 0, lat, rd, err, rdy, st);
        checks++;
        if (lat != 6 || rd !== 32'hDEADBEEF || err !== 1'b0) begin
            errors++;
            $display("FAIL word_load lat=%0d rdata=%h err=%b expected 6/deadbeef/0",
                     lat, rd, err);
        end
    endtask

    task automatic test_sign_ext;
        int lat; logic [31:0] rd; logic err, rdy, st;
        do_txn(1'b1, 2'b00, 1'b0, 12'h020, 32'h12345680, 0, lat, rd, err, rdy, st);
        ref_store(12'h020, 2'b00, 32'h12345680);
        checks++;
        if (lat != 2 || bram[12'h020] !== 8'h80 || bram[12'h021] !== ref_mem[12'h021]) begin
            errors++;
            $display("FAIL byte_store lat=%0d mem=%h/%h expected 2/80/%h",
                     lat, bram[12'h020], bram[12'h021], ref_mem[12'h021]);
        end
        do_txn(1'b0, 2'b00, 1'b1, 12'h020, 32'h0, 0, lat, rd, err, rdy, st);
        checks++;
        if (lat != 3 || rd !== 32'hFFFFFF80) begin
            errors++;
            $display("FAIL byte_load_signed lat=%0d rdata=%h expected 3/ffffff80", lat, rd);
        end
        do_txn(1'b0, 2'b00, 1'b0, 12'h020, 32'h0, 0, lat, rd, err, rdy, st);
        checks++;
        if (rd !== 32'h00000080) begin
            errors++;
            $display("FAIL byte_load_unsigned rdata=%h expected 00000080", rd);
        end
        do_txn(1'b1, 2'b01, 1'b0, 12'h030, 32'h0000A55A, 0, lat, rd, err, rdy, st);
        ref_store(12'h030, 2'b01, 32'h0000A55A);
        do_txn(1'b0, 2'b01, 1'b1, 12'h030, 32'h0, 0, lat, rd, err, rdy, st);
        checks++;
        if (lat != 4 || rd !== 32'hFFFFA55A) begin
            errors++;
            $display("FAIL half_load_signed lat=%0d rdata=%h expected 4/ffffa55a", lat, rd);
        end
        do_txn(1'b0, 2'b11, 1'b1, 12'h010, 32'h0, 0, lat, rd, err, rdy, st);
        checks++;
        if (lat != 6 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL size3_word_load lat=%0d rdata=%h expected 6/deadbeef", lat, rd);
        end
    endtask

    task automatic test_backpressure;
        int lat; logic [31:0] rd; logic err, rdy, st;
        do_txn(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 5, lat, rd, err, rdy, st);
        checks++;
        if (st !== 1'b1 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL backpressure stable=%b rdata=%h expected 1/deadbeef", st, rd);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_handshake rsp_valid=%b req_ready=%b expected 0/1",
                     rsp_valid, req_ready);
        end
    endtask

    task automatic test_wrap;
        int lat; logic [31:0] rd; logic err, rdy, st;
        logic [31:0] exp = ref_load(12'hFFE, 2'b10, 1'b0);
        logic [11:0] exp_a [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        do_txn(1'b0, 2'b10, 1'b0, 12'hFFE, 32'h0, 0, lat, rd, err, rdy, st);
`ifdef BRAM_MASTER_ALIGN_CHECK_EN
        checks++;
        if (lat != 1 || err !== 1'b1 || rd !== 32'h0 || q_rd.size() != 0) begin
            errors++;
            $display("FAIL wrap_misalign lat=%0d err=%b rdata=%h strobes=%0d expected 1/1/0/0",
                     lat, err, rd, q_rd.size());
        end
`else
        checks++;
        if (lat != 6 || err !== 1'b0 || rd !== exp) begin
            errors++;
            $display("FAIL wrap_load lat=%0d err=%b rdata=%h expected 6/0/%h", lat, err, rd, exp);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k >= q_rd.size() || q_rd[k] !== 1'b1 || q_addr[k] !== exp_a[k]) begin
                errors++;
                $display("FAIL wrap_addr%0d got %h expected %h", k,
                         (k < q_addr.size()) ? q_addr[k] : 12'hx, exp_a[k]);
            end
        end
`endif
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] rd; logic err, rdy, st;
        bit seen;
        do_txn(1'b1, 2'b10, 1'b0, 12'h100, 32'h11223344, 0, lat, rd, err, rdy, st);
        ref_store(12'h100, 2'b10, 32'h11223344);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 12'h100;
        req_wdata = 32'hAABBCCDD;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || mem_read !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort we=%b rd=%b rsp_valid=%b expected 0/0/0",
                     mem_we, mem_read, rsp_valid);
        end
        resetn = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || mem_we) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_no_resp activity=%b expected 0", seen);
        end
        ref_mem[12'h100] = 8'hDD;
        ref_mem[12'h101] = 8'hCC;
        checks++;
        if ({bram[12'h103], bram[12'h102], bram[12'h101], bram[12'h100]} !== 32'h1122CCDD) begin
            errors++;
            $display("FAIL reset_partial mem=%h expected 1122ccdd",
                     {bram[12'h103], bram[12'h102], bram[12'h101], bram[12'h100]});
        end
    endtask

    task automatic test_random;
        int lat; logic [31:0] rd; logic err, rdy, st;
        for (int t = 0; t < 60; t++) begin
            logic        we  = 1'($urandom);
            logic [1:0]  sz  = 2'($urandom);
            logic        sg  = 1'($urandom);
            logic [11:0] a   = 12'($urandom);
            logic [31:0] wd  = $urandom;
            int          h   = $urandom_range(0, 3);
            int          n   = nbytes(sz);
            bit          mis = ref_misalign(sz, a);
            int          elat = mis ? 1 : (we ? n + 1 : n + 2);
            logic [31:0] erd = (we || mis) ? 32'h0 : ref_load(a, sz, sg);
            if (t < 8) a = 12'hFFC + 12'(t % 4);
            mis  = ref_misalign(sz, a);
            elat = mis ? 1 : (we ? n + 1 : n + 2);
            erd  = (we || mis) ? 32'h0 : ref_load(a, sz, sg);
            do_txn(we, sz, sg, a, wd, h, lat, rd, err, rdy, st);
            if (we && !mis) ref_store(a, sz, wd);
            checks++;
            if (!rdy || lat != elat || rd !== erd || err !== 1'(mis) || !st) begin
                errors++;
                $display("FAIL rand%0d we=%b sz=%0d a=%h: rdy=%b lat=%0d rd=%h err=%b st=%b expected lat=%0d rd=%h err=%b",
                         t, we, sz, a, rdy, lat, rd, err, st, elat, erd, mis);
            end
            for (int k = 0; k < q_rd.size(); k++) begin
                bit act = (k < n) && !mis;
                checks++;
                if (q_rd[k] !== (act && !we) || q_we[k] !== (act && we)
                    || (act && q_addr[k] !== 12'(int'(a) + k))
                    || (act && we && q_wd[k] !== wd[8*k +: 8])) begin
                    errors++;
                    $display("FAIL rand%0d_cycle%0d rd=%b we=%b addr=%h wd=%h", t, k + 1,
                             q_rd[k], q_we[k], q_addr[k], q_wd[k]);
                end
            end
        end
    endtask

    task automatic test_final_mem;
        int bad = 0;
        for (int i = 0; i < 4096; i++)
            if (bram[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL final_mem got %0d differing bytes expected 0", bad);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            bram[i]    = 8'($urandom);
            ref_mem[i] = bram[i];
        end
        test_reset();
        test_store_load();
        test_sign_ext();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        test_final_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
